// File: rtl/rst_seq_ctrl_if.sv
// Software reset request/acknowledge handshake between a requester (master)
// and the reset sequencing controller (slave).
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  logic               SW_RST_REQ;
  logic [NUM_DOM-1:0] SW_RST_MASK;
  logic               SW_RST_ACK;

  modport master (output SW_RST_REQ, output SW_RST_MASK, input SW_RST_ACK);
  modport slave  (input SW_RST_REQ, input SW_RST_MASK, output SW_RST_ACK);
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: releases NUM_DOM active-low domain resets in
// ascending order and serves masked software resets. Optional: RSTSEQ_REVERSE_ASSERT_EN.
module rst_seq_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int MIN_ASSERT  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               RSTSYNC_CLK,
  input  logic               RSTSYNC_RST,
  rst_seq_ctrl_if.slave      sw,
  output logic [NUM_DOM-1:0] DOM_RST_N,
  output logic               SEQ_BUSY,
  output logic               SEQ_DONE
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [2:0] {HOLD, GAP, RELEASE, IDLE, SW_ASSERT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             cnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_DOM-1:0]     pend;
  logic [NUM_DOM-1:0]     apend;
  logic                   sw_seq;
  logic                   armed;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_DOM-1:0] v);
    lowest_set = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_DOM-1:0] v);
    highest_set = '0;
    for (int i = 0; i < NUM_DOM; i++)
      if (v[i]) highest_set = IDX_W'(i);
  endfunction

  function automatic logic [NUM_DOM-1:0] bit_of(input logic [IDX_W-1:0] i);
    bit_of    = '0;
    bit_of[i] = 1'b1;
  endfunction

  // Global reset deassertion synchronizer
  always_ff @(posedge RSTSYNC_CLK or posedge RSTSYNC_RST) begin
    if (RSTSYNC_RST) sync_q <= '0;
    else             sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge RSTSYNC_CLK or posedge RSTSYNC_RST) begin
    if (RSTSYNC_RST) begin
      state         <= HOLD;
      cnt           <= '0;
      idx           <= '0;
      pend          <= '1;
      apend         <= '0;
      sw_seq        <= 1'b0;
      armed         <= 1'b1;
      DOM_RST_N     <= '0;
      SEQ_BUSY      <= 1'b1;
      SEQ_DONE      <= 1'b0;
      sw.SW_RST_ACK <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1]) begin
      sw.SW_RST_ACK <= 1'b0;
      // A request may only restart after it has been seen low since the last ACK
      if (!sw.SW_RST_REQ) armed <= 1'b1;
      case (state)
        HOLD: begin
          if (cnt == 8'(MIN_ASSERT - 1)) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= lowest_set(pend);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        GAP: begin
          if (cnt == 8'(GAP_CYCLES - 1)) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= lowest_set(pend);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        RELEASE: begin
          DOM_RST_N[idx] <= 1'b1;
          pend           <= pend & ~bit_of(idx);
          if ((pend & ~bit_of(idx)) == '0) begin
            state    <= IDLE;
            SEQ_BUSY <= 1'b0;
            SEQ_DONE <= 1'b1;
            sw_seq   <= 1'b0;
            if (sw_seq) begin
              sw.SW_RST_ACK <= 1'b1;
              armed         <= 1'b0;
            end
          end else begin
            state <= GAP;
          end
        end
        IDLE: begin
          if (sw.SW_RST_REQ && armed) begin
            state    <= SW_ASSERT;
            SEQ_BUSY <= 1'b1;
            SEQ_DONE <= 1'b0;
            sw_seq   <= 1'b1;
            cnt      <= '0;
            pend     <= sw.SW_RST_MASK;
`ifdef RSTSEQ_REVERSE_ASSERT_EN
            // Highest masked domain drops first; the rest follow GAP_CYCLES+1 apart
            if (sw.SW_RST_MASK != '0)
              DOM_RST_N <= DOM_RST_N & ~bit_of(highest_set(sw.SW_RST_MASK));
            apend <= sw.SW_RST_MASK & ~bit_of(highest_set(sw.SW_RST_MASK));
`else
            DOM_RST_N <= DOM_RST_N & ~sw.SW_RST_MASK;
            apend     <= '0;
`endif
          end
        end
        SW_ASSERT: begin
          if (apend != '0) begin
            if (cnt == 8'(GAP_CYCLES)) begin
              DOM_RST_N <= DOM_RST_N & ~bit_of(highest_set(apend));
              apend     <= apend & ~bit_of(highest_set(apend));
              cnt       <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end else if (pend == '0 || cnt == 8'(MIN_ASSERT - 1)) begin
            // An empty mask skips the hold and acknowledges straight away
            state <= RELEASE;
            cnt   <= '0;
            idx   <= lowest_set(pend);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
